// File: rtl/mem_access_pkg.sv
// Shared types for the memory-access stage.
//   instructions : decoded-instruction fields the stage consumes
//   FUNCT3_*     : RV32I load/store width encodings
//   mem_state_t  : memory-access FSM state encoding
//   is_misaligned: natural-alignment check for a load/store width
package mem_access_pkg;

    typedef struct packed {
        logic       is_load;
        logic       is_store;
        logic [2:0] funct3;
        logic [4:0] rd;
    } instructions;

    localparam logic [2:0] FUNCT3_B  = 3'b000;
    localparam logic [2:0] FUNCT3_H  = 3'b001;
    localparam logic [2:0] FUNCT3_W  = 3'b010;
    localparam logic [2:0] FUNCT3_BU = 3'b100;
    localparam logic [2:0] FUNCT3_HU = 3'b101;

    typedef enum logic [1:0] {
        MA_IDLE,
        MA_REQ,
        MA_WAIT_R,
        MA_DONE
    } mem_state_t;

    // funct3[1:0] encodes the access size for both loads and stores
    // (00 byte, 01 half, 1x word); funct3[2] only selects zero-extension.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
        logic mis;
        case (funct3[1:0])
            2'b00:   mis = 1'b0;
            2'b01:   mis = addr_lo[0];
            default: mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Load data alignment: picks the byte/half lane addressed by addr_lo out of
// the returned word and sign- or zero-extends it to 32 bits.
//   rdata    in  32  word returned by data memory
//   addr_lo  in   2  low address bits of the access
//   funct3   in   3  load width / signedness
//   value    out 32  extended load result
module mem_access_load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] value
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        case (funct3)
            FUNCT3_B:  value = {{24{byte_lane[7]}}, byte_lane};
            FUNCT3_BU: value = {24'd0, byte_lane};
            FUNCT3_H:  value = {{16{half_lane[15]}}, half_lane};
            FUNCT3_HU: value = {16'd0, half_lane};
            default:   value = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage of the multicycle RV32I core (between execute and write).
// Issues loads/stores over a req/ready + rvalid data-memory port, aligns and
// extends load data, passes the ALU result through for non-memory ops, and
// hands a 32-bit result to write with the enabled/completed protocol.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   MA_IDLE   | no operation since reset; waits for enabled
//   MA_REQ    | mem_req asserted, waiting for mem_ready
//   MA_WAIT_R | load accepted by memory, waiting for mem_rvalid
//   MA_DONE   | result valid, completed high; accepts enabled like IDLE
//
// Ports:
//   clk, rst (sync, active-high)
//   enabled, instr, alu_result, rs2_data       : start pulse and operands
//   mem_req/we/addr/wdata/wstrb, mem_ready     : request channel
//   mem_rvalid, mem_rdata                      : load response
//   result, misaligned, bus_err, completed     : to write stage
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enabled,
    input  instructions instr,
    input  logic [31:0] alu_result,
    input  logic [31:0] rs2_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] result,
    output logic        misaligned,
    output logic        bus_err,
    output logic        completed
);

    // Timeout is a down-counter loaded on entry to REQ/WAIT_R; terminal count
    // (zero) with no handshake in the same cycle means the limit was reached.
    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LOAD =
        TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    mem_state_t    state_q, state_d;
    logic          done_q, done_d;
    logic          misaligned_q, misaligned_d;
    logic          bus_err_q, bus_err_d;
    logic [31:0]   result_q, result_d;
    logic          is_store_q, is_store_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   rs2_q, rs2_d;
    logic [TW-1:0] timer_q, timer_d;

    logic [31:0]   load_value;
    logic          timeout_hit;
    logic          mem_op;
    logic [3:0]    store_strb;

    // rd is carried for the write stage elsewhere; nothing here needs it.
    logic          unused_rd;
    assign unused_rd = ^instr.rd;

    mem_access_load_align u_load_align (
        .rdata   (mem_rdata),
        .addr_lo (addr_q[1:0]),
        .funct3  (funct3_q),
        .value   (load_value)
    );

    assign timeout_hit = TIMEOUT_EN && (timer_q == '0);
    assign mem_op      = instr.is_load | instr.is_store;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= MA_IDLE;
            done_q       <= 1'b0;
            misaligned_q <= 1'b0;
            bus_err_q    <= 1'b0;
            result_q     <= 32'd0;
            is_store_q   <= 1'b0;
            funct3_q     <= 3'd0;
            addr_q       <= 32'd0;
            rs2_q        <= 32'd0;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            done_q       <= done_d;
            misaligned_q <= misaligned_d;
            bus_err_q    <= bus_err_d;
            result_q     <= result_d;
            is_store_q   <= is_store_d;
            funct3_q     <= funct3_d;
            addr_q       <= addr_d;
            rs2_q        <= rs2_d;
            timer_q      <= timer_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        done_d       = done_q;
        misaligned_d = misaligned_q;
        bus_err_d    = bus_err_q;
        result_d     = result_q;
        is_store_d   = is_store_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        rs2_d        = rs2_q;
        timer_d      = timer_q;

        case (state_q)
            MA_IDLE, MA_DONE: begin
                if (enabled) begin
                    done_d       = 1'b0;
                    misaligned_d = 1'b0;
                    bus_err_d    = 1'b0;
                    // A load flag wins if the decoder ever sets both.
                    is_store_d   = instr.is_store & ~instr.is_load;
                    funct3_d     = instr.funct3;
                    addr_d       = alu_result;
                    rs2_d        = rs2_data;
                    if (!mem_op) begin
                        result_d = alu_result;
                        done_d   = 1'b1;
                        state_d  = MA_DONE;
                    end else if (is_misaligned(instr.funct3, alu_result[1:0])) begin
                        misaligned_d = 1'b1;
                        result_d     = 32'd0;
                        done_d       = 1'b1;
                        state_d      = MA_DONE;
                    end else begin
                        timer_d = TIMER_LOAD;
                        state_d = MA_REQ;
                    end
                end
            end
            MA_REQ: begin
                if (mem_ready) begin
                    if (is_store_q) begin
                        done_d  = 1'b1;
                        state_d = MA_DONE;
                    end else begin
                        timer_d = TIMER_LOAD;
                        state_d = MA_WAIT_R;
                    end
                end else if (timeout_hit) begin
                    bus_err_d = 1'b1;
                    result_d  = 32'd0;
                    done_d    = 1'b1;
                    state_d   = MA_DONE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            MA_WAIT_R: begin
                if (mem_rvalid) begin
                    result_d = load_value;
                    done_d   = 1'b1;
                    state_d  = MA_DONE;
                end else if (timeout_hit) begin
                    bus_err_d = 1'b1;
                    result_d  = 32'd0;
                    done_d    = 1'b1;
                    state_d   = MA_DONE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: state_d = MA_IDLE;
        endcase
    end

    always_comb begin
        case (funct3_q[1:0])
            2'b00: begin
                mem_wdata  = {4{rs2_q[7:0]}};
                store_strb = 4'b0001 << addr_q[1:0];
            end
            2'b01: begin
                mem_wdata  = {2{rs2_q[15:0]}};
                store_strb = addr_q[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                mem_wdata  = rs2_q;
                store_strb = 4'b1111;
            end
        endcase

        mem_req    = (state_q == MA_REQ);
        mem_we     = mem_req & is_store_q;
        mem_wstrb  = mem_we ? store_strb : 4'b0000;
        mem_addr   = {addr_q[31:2], 2'b00};
        result     = result_q;
        misaligned = misaligned_q;
        bus_err    = bus_err_q;
        completed  = done_q & ~enabled;
    end

endmodule
